menu_button_ctrl: RTL and testbench

Mouse-side controller for the main-menu screen. Hit-tests the mouse cursor against the Start and Connect button rectangles and drives the hover flags consumed by the menu pixel generator. Turns press-then-release gestures into one-cycle action pulses. Also owns the `connecting` status flag and its completion/timeout handshake with the link logic.

---
 rtl/menu_button_ctrl.sv | 164 ++++++++++++++++
 tb/tb_menu_button_ctrl.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/menu_button_ctrl.sv
// Main-menu mouse controller: registered Start/Connect hover flags, press-then-release click pulses
// and the connect attempt handshake. Hover is 1 cycle from position; all pulses are registered, 1 cycle wide.
module menu_button_ctrl #(
    parameter int unsigned START_X0        = 220,
    parameter int unsigned START_X1        = 419,
    parameter int unsigned START_Y0        = 230,
    parameter int unsigned START_Y1        = 289,
    parameter int unsigned CONN_X0         = 220,
    parameter int unsigned CONN_X1         = 419,
    parameter int unsigned CONN_Y0         = 330,
    parameter int unsigned CONN_Y1         = 389,
    parameter int unsigned CONNECT_TIMEOUT = 100_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [9:0] MOUSE_X_POS,
    input  logic [9:0] MOUSE_Y_POS,
    input  logic       MOUSE_LEFT,
    input  logic       connect_done,
    output logic       mouse_on_start_button,
    output logic       mouse_on_connect_button,
    output logic       start_pulse,
    output logic       connecting,
    output logic       connect_ok,
    output logic       connect_fail
);

    localparam int unsigned CNT_W = (CONNECT_TIMEOUT > 1) ? $clog2(CONNECT_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CONNECT_TIMEOUT - 1);

    localparam logic [9:0] S_X0 = 10'(START_X0);
    localparam logic [9:0] S_X1 = 10'(START_X1);
    localparam logic [9:0] S_Y0 = 10'(START_Y0);
    localparam logic [9:0] S_Y1 = 10'(START_Y1);
    localparam logic [9:0] C_X0 = 10'(CONN_X0);
    localparam logic [9:0] C_X1 = 10'(CONN_X1);
    localparam logic [9:0] C_Y0 = 10'(CONN_Y0);
    localparam logic [9:0] C_Y1 = 10'(CONN_Y1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARM_START,
        ST_ARM_CONNECT,
        ST_CONNECTING
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             left_q, left_d;
    logic             on_start_q, on_start_d;
    logic             on_conn_q, on_conn_d;
    logic             start_pulse_q, start_pulse_d;
    logic             connecting_q, connecting_d;
    logic             connect_ok_q, connect_ok_d;
    logic             connect_fail_q, connect_fail_d;

    logic             hit_start;
    logic             hit_conn;
    logic             press;

    always_comb begin
        hit_start = enable
                    && (MOUSE_X_POS >= S_X0) && (MOUSE_X_POS <= S_X1)
                    && (MOUSE_Y_POS >= S_Y0) && (MOUSE_Y_POS <= S_Y1);
        hit_conn  = enable
                    && (MOUSE_X_POS >= C_X0) && (MOUSE_X_POS <= C_X1)
                    && (MOUSE_Y_POS >= C_Y0) && (MOUSE_Y_POS <= C_Y1);
        press     = MOUSE_LEFT & ~left_q;
    end

    // Arm/release decisions look at the registered hover flags, i.e. last cycle's position.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        left_d         = MOUSE_LEFT;
        on_start_d     = hit_start;
        on_conn_d      = hit_conn;
        start_pulse_d  = 1'b0;
        connect_ok_d   = 1'b0;
        connect_fail_d = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (enable && press) begin
                    if (on_start_q) begin
                        state_d = ST_ARM_START;
                    end else if (on_conn_q) begin
                        state_d = ST_ARM_CONNECT;
                    end
                end
            end
            ST_ARM_START: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                end else if (!MOUSE_LEFT) begin
                    start_pulse_d = on_start_q;
                    state_d       = ST_IDLE;
                end
            end
            ST_ARM_CONNECT: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                end else if (!MOUSE_LEFT) begin
                    if (on_conn_q) begin
                        state_d = ST_CONNECTING;
                        cnt_d   = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_CONNECTING: begin
                // A completion arriving in the last timeout cycle still counts as success.
                if (connect_done) begin
                    connect_ok_d = 1'b1;
                    state_d      = ST_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    connect_fail_d = 1'b1;
                    state_d        = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        connecting_d = (state_d == ST_CONNECTING);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            left_q         <= 1'b0;
            on_start_q     <= 1'b0;
            on_conn_q      <= 1'b0;
            start_pulse_q  <= 1'b0;
            connecting_q   <= 1'b0;
            connect_ok_q   <= 1'b0;
            connect_fail_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            left_q         <= left_d;
            on_start_q     <= on_start_d;
            on_conn_q      <= on_conn_d;
            start_pulse_q  <= start_pulse_d;
            connecting_q   <= connecting_d;
            connect_ok_q   <= connect_ok_d;
            connect_fail_q <= connect_fail_d;
        end
    end

    assign mouse_on_start_button   = on_start_q;
    assign mouse_on_connect_button = on_conn_q;
    assign start_pulse             = start_pulse_q;
    assign connecting              = connecting_q;
    assign connect_ok              = connect_ok_q;
    assign connect_fail            = connect_fail_q;

endmodule

// File: tb/tb_menu_button_ctrl.sv
// Scoreboard bench for menu_button_ctrl: a gesture-level reference model predicts every cycle's outputs,
// a negedge monitor pops and compares them; directed scenarios add event-count checks.
module tb_menu_button_ctrl;

    localparam int T = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b0;
    logic [9:0] mx = '0;
    logic [9:0] my = '0;
    logic       ml = 1'b0;
    logic       done = 1'b0;
    logic       hs, hc, sp, cn, ok, fl;

    always #5 clk = ~clk;

    menu_button_ctrl #(.CONNECT_TIMEOUT(T)) dut (
        .clk                     (clk),
        .rst                     (rst),
        .enable                  (enable),
        .MOUSE_X_POS             (mx),
        .MOUSE_Y_POS             (my),
        .MOUSE_LEFT              (ml),
        .connect_done            (done),
        .mouse_on_start_button   (hs),
        .mouse_on_connect_button (hc),
        .start_pulse             (sp),
        .connecting              (cn),
        .connect_ok              (ok),
        .connect_fail            (fl)
    );

    typedef struct packed {
        logic hs, hc, sp, cn, ok, fl;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_fail = 0;

    // Reference model: what the user did, not how the RTL encodes it.
    int   m_prev_left = 0;
    int   m_hover_s   = 0;
    int   m_hover_c   = 0;
    int   m_armed     = 0;   // 0 nothing held, 1 Start held, 2 Connect held
    int   m_busy      = 0;
    int   m_age       = 0;   // cycles the current attempt has been visible

    int   obs_sp = 0, obs_ok = 0, obs_fl = 0, cur_run = 0, last_run = 0;

    function automatic int in_rect(int x, int y, int x0, int x1, int y0, int y1);
        return (x >= x0 && x <= x1 && y >= y0 && y <= y1) ? 1 : 0;
    endfunction

    task automatic chk(input string nm, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, req);
        end
    endtask

    task automatic step(input int r, input int en, input int l, input int d, input int x, input int y);
        exp_t e;
        rst    = (r != 0);
        enable = (en != 0);
        ml     = (l != 0);
        done   = (d != 0);
        mx     = 10'(x);
        my     = 10'(y);
        e = '0;
        if (r != 0) begin
            m_prev_left = 0; m_hover_s = 0; m_hover_c = 0;
            m_armed = 0; m_busy = 0; m_age = 0;
        end else begin
            if (m_busy != 0) begin
                if (d != 0) begin
                    e.ok = 1'b1; m_busy = 0;
                end else if (m_age == T) begin
                    e.fl = 1'b1; m_busy = 0;
                end else begin
                    m_age++;
                end
            end else if (m_armed != 0) begin
                if (en == 0) begin
                    m_armed = 0;
                end else if (l == 0) begin
                    if (m_armed == 1 && m_hover_s != 0) e.sp = 1'b1;
                    if (m_armed == 2 && m_hover_c != 0) begin
                        m_busy = 1; m_age = 1;
                    end
                    m_armed = 0;
                end
            end else if (en != 0 && l != 0 && m_prev_left == 0) begin
                if (m_hover_s != 0) m_armed = 1;
                else if (m_hover_c != 0) m_armed = 2;
            end
            m_prev_left = l;
            m_hover_s = (en != 0) ? in_rect(x, y, 220, 419, 230, 289) : 0;
            m_hover_c = (en != 0) ? in_rect(x, y, 220, 419, 330, 389) : 0;
        end
        e.hs = (m_hover_s != 0);
        e.hc = (m_hover_c != 0);
        e.cn = (m_busy != 0);
        q.push_back(e);
        @(negedge clk);
        #1;
    endtask

    task automatic mv(input int x, input int y, input int l, input int d);
        step(0, 1, l, d, x, y);
    endtask

    task automatic click(input int x, input int y, input int hold);
        mv(x, y, 0, 0);
        mv(x, y, 0, 0);
        for (int i = 0; i < hold; i++) mv(x, y, 1, 0);
        mv(x, y, 0, 0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sp) obs_sp++;
            if (ok) obs_ok++;
            if (fl) obs_fl++;
            if (cn) cur_run++;
            else if (cur_run > 0) begin
                last_run = cur_run;
                cur_run = 0;
            end
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("hover_start", int'(hs), int'(e.hs));
                chk("hover_connect", int'(hc), int'(e.hc));
                chk("start_pulse", int'(sp), int'(e.sp));
                chk("connecting", int'(cn), int'(e.cn));
                chk("connect_ok", int'(ok), int'(e.ok));
                chk("connect_fail", int'(fl), int'(e.fl));
                chk("pulse_exclusive", (int'(sp) + int'(ok) + int'(fl)) <= 1 ? 1 : 0, 1);
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: bench did not finish within time limit");
        $fatal(1, "timeout");
    end

    initial begin : driver
        int b_sp, b_ok, b_fl, x, y, l;

        for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 0, 0);
        chk("reset_start_pulse", int'(sp), 0);
        chk("reset_connecting", int'(cn), 0);

        // Start click
        b_sp = obs_sp;
        click(300, 250, 5);
        chk("start_hover_during_click", int'(hs), 1);
        mv(300, 250, 0, 0);
        mv(300, 250, 0, 0);
        chk("start_click_count", obs_sp - b_sp, 1);

        // Inclusive corner, one past it
        mv(419, 289, 0, 0);
        mv(419, 289, 0, 0);
        chk("edge_hover_in", int'(hs), 1);
        mv(420, 289, 0, 0);
        chk("edge_hover_out", int'(hs), 0);

        // Drag-off and drag-in
        b_sp = obs_sp;
        mv(300, 250, 0, 0);
        mv(300, 250, 1, 0);
        mv(300, 270, 1, 0);
        mv(300, 300, 1, 0);
        mv(300, 300, 0, 0);
        mv(300, 300, 0, 0);
        mv(100, 100, 1, 0);
        mv(200, 200, 1, 0);
        mv(300, 250, 1, 0);
        mv(300, 250, 1, 0);
        mv(300, 250, 0, 0);
        mv(300, 250, 0, 0);
        chk("drag_no_pulse", obs_sp - b_sp, 0);

        // Connect success at attempt cycle 10, with a Start click ignored meanwhile
        b_sp = obs_sp; b_ok = obs_ok; b_fl = obs_fl;
        click(300, 350, 3);
        chk("connecting_after_click", int'(cn), 1);
        for (int i = 0; i < 40 && m_busy != 0; i++) begin
            l = (m_age >= 3 && m_age <= 5) ? 1 : 0;
            mv(300, 250, l, (m_age == 10) ? 1 : 0);
        end
        mv(300, 250, 0, 0);
        chk("success_ok_count", obs_ok - b_ok, 1);
        chk("success_no_fail", obs_fl - b_fl, 0);
        chk("success_run_len", last_run, 10);
        chk("no_start_while_connecting", obs_sp - b_sp, 0);

        // Timeout
        b_ok = obs_ok; b_fl = obs_fl;
        click(300, 350, 2);
        for (int i = 0; i < 40; i++) mv(300, 350, 0, 0);
        chk("timeout_run_len", last_run, T);
        chk("timeout_fail_count", obs_fl - b_fl, 1);
        chk("timeout_no_ok", obs_ok - b_ok, 0);

        // Completion in the final cycle wins
        b_ok = obs_ok; b_fl = obs_fl;
        click(300, 350, 2);
        for (int i = 0; i < 40 && m_busy != 0; i++) mv(300, 350, 0, (m_age == T) ? 1 : 0);
        mv(300, 350, 0, 0);
        chk("tie_ok_count", obs_ok - b_ok, 1);
        chk("tie_no_fail", obs_fl - b_fl, 0);
        chk("tie_run_len", last_run, T);

        // Reset during an attempt
        b_fl = obs_fl;
        click(300, 350, 2);
        for (int i = 0; i < 5; i++) mv(300, 350, 0, 0);
        step(1, 1, 0, 0, 300, 350);
        chk("rst_drops_connecting", int'(cn), 0);
        chk("rst_clears_hover", int'(hc), 0);
        for (int i = 0; i < 25; i++) mv(300, 350, 0, 0);
        chk("rst_no_fail", obs_fl - b_fl, 0);

        // Enable dropped while Start is armed
        b_sp = obs_sp;
        mv(300, 250, 0, 0);
        mv(300, 250, 0, 0);
        mv(300, 250, 1, 0);
        mv(300, 250, 1, 0);
        step(0, 0, 1, 0, 300, 250);
        chk("disable_hover_zero", int'(hs), 0);
        mv(300, 250, 1, 0);
        mv(300, 250, 0, 0);
        mv(300, 250, 0, 0);
        chk("disable_no_pulse", obs_sp - b_sp, 0);

        // Randomised traffic
        x = 300; y = 250; l = 0;
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 4) == 0) begin
                if ($urandom_range(0, 4) != 0) begin
                    x = int'($urandom_range(200, 440));
                    y = int'($urandom_range(210, 410));
                end else begin
                    x = int'($urandom_range(0, 639));
                    y = int'($urandom_range(0, 479));
                end
            end
            if ($urandom_range(0, 3) == 0) l = 1 - l;
            step(($urandom_range(0, 199) == 0) ? 1 : 0,
                 ($urandom_range(0, 29) != 0) ? 1 : 0,
                 l,
                 ($urandom_range(0, 19) == 0) ? 1 : 0,
                 x, y);
        end

        mv(0, 0, 0, 0);
        chk("queue_drained", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
